// File: rtl/reg_status_table.sv
// reg_status_table: per-architectural-register pending/producer-row tracker.
// Four combinational read ports feed the hazard detector; allocate, writeback
// clear and flush update the table on the rising clock edge.
// Optional build macro RST_WB_BYPASS_EN: a read whose entry is cleared by the
// writeback broadcast in the current cycle already reports pending 0.
module reg_status_table #(
    parameter int ROW_W = 5,
    parameter int NREGS = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       iss_rs_a,
    input  logic [4:0]       iss_rs_b,
    output logic             iss_ass_pending_a,
    output logic             iss_ass_pending_b,
    output logic [ROW_W-1:0] iss_ass_row_a,
    output logic [ROW_W-1:0] iss_ass_row_b,
    input  logic [4:0]       id_rs_a,
    input  logic [4:0]       id_rs_b,
    output logic             id_ass_pending_a,
    output logic             id_ass_pending_b,
    output logic [ROW_W-1:0] id_ass_row_a,
    output logic [ROW_W-1:0] id_ass_row_b,
    input  logic             alloc_en,
    input  logic [4:0]       alloc_reg,
    input  logic [ROW_W-1:0] alloc_row,
    input  logic             wb_en,
    input  logic [ROW_W-1:0] wb_row,
    input  logic             flush,
    output logic [5:0]       pending_count
);

    localparam int IDX_W = 5;

    logic [NREGS-1:0] pend_q, pend_d;
    logic [ROW_W-1:0] row_q [NREGS];
    logic [ROW_W-1:0] row_d [NREGS];
    logic [5:0]       pending_count_q, pending_count_d;

    // Next-state per entry: flush > alloc > writeback clear > hold; r0 pinned to zero.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            pend_d[i] = pend_q[i];
            row_d[i]  = row_q[i];
            if (flush) begin
                pend_d[i] = 1'b0;
            end else if (alloc_en && (alloc_reg == IDX_W'(i))) begin
                pend_d[i] = 1'b1;
                row_d[i]  = alloc_row;
            end else if (wb_en && pend_q[i] && (row_q[i] == wb_row)) begin
                pend_d[i] = 1'b0;
            end
            if (i == 0) begin
                pend_d[i] = 1'b0;
                row_d[i]  = '0;
            end
        end
    end

    // Population count of the next-state pending vector.
    always_comb begin
        pending_count_d = '0;
        for (int i = 0; i < NREGS; i++) begin
            pending_count_d = pending_count_d + 6'(pend_d[i]);
        end
    end

    // Table state and registered count; reset wipes pend and row alike.
    always_ff @(posedge clock) begin
        if (reset) begin
            pend_q          <= '0;
            pending_count_q <= '0;
            for (int i = 0; i < NREGS; i++) begin
                row_q[i] <= '0;
            end
        end else begin
            pend_q          <= pend_d;
            pending_count_q <= pending_count_d;
            for (int i = 0; i < NREGS; i++) begin
                row_q[i] <= row_d[i];
            end
        end
    end

    // Pending flag as seen by a read port (r0 always idle).
    function automatic logic read_pend(input logic [4:0] idx);
        logic p;
        p = (idx != '0) && pend_q[idx];
`ifdef RST_WB_BYPASS_EN
        // An entry being re-allocated this cycle shows its old state unbypassed.
        if (p && wb_en && (row_q[idx] == wb_row) &&
            !(alloc_en && (alloc_reg == idx))) begin
            p = 1'b0;
        end
`endif
        return p;
    endfunction

    // Producer row as seen by a read port (r0 always zero).
    function automatic logic [ROW_W-1:0] read_row(input logic [4:0] idx);
        return (idx == '0) ? '0 : row_q[idx];
    endfunction

    // Four independent zero-latency read ports.
    always_comb begin
        iss_ass_pending_a = read_pend(iss_rs_a);
        iss_ass_pending_b = read_pend(iss_rs_b);
        id_ass_pending_a  = read_pend(id_rs_a);
        id_ass_pending_b  = read_pend(id_rs_b);
        iss_ass_row_a     = read_row(iss_rs_a);
        iss_ass_row_b     = read_row(iss_rs_b);
        id_ass_row_a      = read_row(id_rs_a);
        id_ass_row_b      = read_row(id_rs_b);
    end

    assign pending_count = pending_count_q;

endmodule

// File: tb/tb_reg_status_table.sv
// Testbench for reg_status_table: directed vector table, hand sequences for
// same-cycle corner cases, and randomized traffic against a reference model.
module tb_reg_status_table;

  localparam int ROW_W = 5;
`ifdef RST_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset;
  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [4:0]       iss_rs_a, iss_rs_b, id_rs_a, id_rs_b;
  logic             iss_ass_pending_a, iss_ass_pending_b;
  logic             id_ass_pending_a, id_ass_pending_b;
  logic [ROW_W-1:0] iss_ass_row_a, iss_ass_row_b, id_ass_row_a, id_ass_row_b;
  logic             alloc_en, wb_en, flush;
  logic [4:0]       alloc_reg;
  logic [ROW_W-1:0] alloc_row, wb_row;
  logic [5:0]       pending_count;

  reg_status_table #(.ROW_W(ROW_W), .NREGS(32)) dut (
    .clock(clock), .reset(reset),
    .iss_rs_a(iss_rs_a), .iss_rs_b(iss_rs_b),
    .iss_ass_pending_a(iss_ass_pending_a), .iss_ass_pending_b(iss_ass_pending_b),
    .iss_ass_row_a(iss_ass_row_a), .iss_ass_row_b(iss_ass_row_b),
    .id_rs_a(id_rs_a), .id_rs_b(id_rs_b),
    .id_ass_pending_a(id_ass_pending_a), .id_ass_pending_b(id_ass_pending_b),
    .id_ass_row_a(id_ass_row_a), .id_ass_row_b(id_ass_row_b),
    .alloc_en(alloc_en), .alloc_reg(alloc_reg), .alloc_row(alloc_row),
    .wb_en(wb_en), .wb_row(wb_row), .flush(flush),
    .pending_count(pending_count)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit               m_pend [32];
  logic [ROW_W-1:0] m_row  [32];

  function automatic int m_count();
    int n = 0;
    foreach (m_pend[r]) n += int'(m_pend[r]);
    return n;
  endfunction

  function automatic bit m_rd_pend(input logic [4:0] idx);
    bit p;
    if (idx == 0) return 1'b0;
    p = m_pend[idx];
    if (BYP && p && wb_en && m_row[idx] == wb_row && !(alloc_en && alloc_reg == idx))
      p = 1'b0;
    return p;
  endfunction

  function automatic logic [ROW_W-1:0] m_rd_row(input logic [4:0] idx);
    return (idx == 0) ? '0 : m_row[idx];
  endfunction

  // Effect of one clock edge, given the inputs present at that edge.
  task automatic model_update();
    if (reset) begin
      foreach (m_pend[r]) begin m_pend[r] = 1'b0; m_row[r] = '0; end
    end else if (flush) begin
      foreach (m_pend[r]) m_pend[r] = 1'b0;
    end else begin
      foreach (m_pend[r])
        if (wb_en && m_pend[r] && m_row[r] == wb_row) m_pend[r] = 1'b0;
      if (alloc_en && alloc_reg != 0) begin
        m_pend[alloc_reg] = 1'b1;
        m_row[alloc_reg]  = alloc_row;
      end
    end
  endtask

  task automatic check_reads();
    chk("iss_pend_a", 32'(iss_ass_pending_a), 32'(m_rd_pend(iss_rs_a)));
    chk("iss_pend_b", 32'(iss_ass_pending_b), 32'(m_rd_pend(iss_rs_b)));
    chk("id_pend_a",  32'(id_ass_pending_a),  32'(m_rd_pend(id_rs_a)));
    chk("id_pend_b",  32'(id_ass_pending_b),  32'(m_rd_pend(id_rs_b)));
    chk("iss_row_a",  32'(iss_ass_row_a),     32'(m_rd_row(iss_rs_a)));
    chk("iss_row_b",  32'(iss_ass_row_b),     32'(m_rd_row(iss_rs_b)));
    chk("id_row_a",   32'(id_ass_row_a),      32'(m_rd_row(id_rs_a)));
    chk("id_row_b",   32'(id_ass_row_b),      32'(m_rd_row(id_rs_b)));
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_strobes();
    alloc_en = 0; alloc_reg = 0; alloc_row = 0;
    wb_en = 0; wb_row = 0; flush = 0; reset = 0;
  endtask

  task automatic set_rd(input logic [4:0] r);
    iss_rs_a = r; iss_rs_b = r; id_rs_a = r; id_rs_b = r;
  endtask

  // Check reads mid-cycle, take one edge, then check the registered count.
  task automatic tick(input bit do_reads);
    if (do_reads) begin #1; check_reads(); end
    @(posedge clock);
    model_update();
    #1;
    chk("pending_count", 32'(pending_count), 32'(m_count()));
  endtask

  task automatic check_all_zero(input string tag);
    for (int r = 0; r < 32; r++) begin
      iss_rs_a = 5'(r); iss_rs_b = 5'(31 - r); id_rs_a = 5'(r); id_rs_b = 5'(31 - r);
      #1;
      chk({tag, "_iss_a"}, {iss_ass_pending_a, 26'(iss_ass_row_a)}, 32'd0);
      chk({tag, "_iss_b"}, {iss_ass_pending_b, 26'(iss_ass_row_b)}, 32'd0);
      chk({tag, "_id_a"},  {id_ass_pending_a,  26'(id_ass_row_a)},  32'd0);
      chk({tag, "_id_b"},  {id_ass_pending_b,  26'(id_ass_row_b)},  32'd0);
    end
    chk({tag, "_count"}, 32'(pending_count), 32'd0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic             a_en;
    logic [4:0]       a_reg;
    logic [ROW_W-1:0] a_row;
    logic             w_en;
    logic [ROW_W-1:0] w_row;
    logic             fl;
    logic [4:0]       rd;
    logic             e_pend;
    logic [ROW_W-1:0] e_row;
    logic [5:0]       e_cnt;
  } vec_t;

  vec_t vecs [12];

  initial begin
    foreach (m_pend[r]) begin m_pend[r] = 1'b0; m_row[r] = '0; end
    clear_strobes();
    set_rd(0);

    //        a_en a_reg a_row w_en w_row fl rd  pend row cnt
    vecs[0]  = '{1, 5,  3,  0, 0, 0, 5,  1, 3,  1};
    vecs[1]  = '{1, 7,  9,  0, 0, 0, 7,  1, 9,  2};
    vecs[2]  = '{1, 0,  4,  0, 0, 0, 0,  0, 0,  2};
    vecs[3]  = '{1, 5,  12, 0, 0, 0, 5,  1, 12, 2};
    vecs[4]  = '{0, 0,  0,  1, 3, 0, 5,  1, 12, 2};
    vecs[5]  = '{0, 0,  0,  1, 12,0, 5,  0, 12, 1};
    vecs[6]  = '{1, 8,  6,  0, 0, 0, 8,  1, 6,  2};
    vecs[7]  = '{1, 8,  6,  1, 6, 0, 8,  1, 6,  2};
    vecs[8]  = '{1, 11, 6,  0, 0, 0, 11, 1, 6,  3};
    vecs[9]  = '{0, 0,  0,  1, 6, 0, 11, 0, 6,  1};
    vecs[10] = '{1, 9,  1,  0, 0, 1, 9,  0, 0,  0};
    vecs[11] = '{0, 0,  0,  0, 0, 0, 7,  0, 9,  0};

    // Power-on reset, then every index on every port reads idle.
    reset = 1;
    tick(0);
    reset = 0;
    check_all_zero("reset");

    for (int v = 0; v < 12; v++) begin
      alloc_en = vecs[v].a_en; alloc_reg = vecs[v].a_reg; alloc_row = vecs[v].a_row;
      wb_en = vecs[v].w_en; wb_row = vecs[v].w_row; flush = vecs[v].fl;
      tick(1);
      clear_strobes();
      set_rd(vecs[v].rd);
      #1;
      chk($sformatf("vec%0d_pend", v), 32'(iss_ass_pending_a), 32'(vecs[v].e_pend));
      chk($sformatf("vec%0d_pend_idb", v), 32'(id_ass_pending_b), 32'(vecs[v].e_pend));
      chk($sformatf("vec%0d_row", v), 32'(iss_ass_row_a), 32'(vecs[v].e_row));
      chk($sformatf("vec%0d_cnt", v), 32'(pending_count), 32'(vecs[v].e_cnt));
    end

    // Writeback bypass: same-cycle view depends on the build, next cycle idle.
    alloc_en = 1; alloc_reg = 10; alloc_row = 2;
    tick(1);
    clear_strobes();
    wb_en = 1; wb_row = 2; set_rd(10);
    #1;
    chk("bypass_same_cycle", 32'(iss_ass_pending_a), BYP ? 32'd0 : 32'd1);
    chk("bypass_row", 32'(iss_ass_row_a), 32'd2);
    tick(0);
    clear_strobes();
    #1;
    chk("bypass_next_cycle", 32'(iss_ass_pending_a), 32'd0);

    // Re-allocation in the writeback cycle shows the old pending state.
    alloc_en = 1; alloc_reg = 10; alloc_row = 2;
    tick(1);
    alloc_row = 4; wb_en = 1; wb_row = 2; set_rd(10);
    #1;
    chk("realloc_no_bypass_pend", 32'(id_ass_pending_a), 32'd1);
    chk("realloc_no_bypass_row", 32'(id_ass_row_a), 32'd2);
    tick(0);
    clear_strobes();
    #1;
    chk("realloc_after_pend", 32'(iss_ass_pending_b), 32'd1);
    chk("realloc_after_row", 32'(iss_ass_row_b), 32'd4);

    // Fill all 31 writable entries, then reset alongside a writeback.
    alloc_en = 1;
    for (int r = 1; r < 32; r++) begin
      alloc_reg = 5'(r); alloc_row = 5'(r);
      tick(1);
    end
    clear_strobes();
    #1;
    chk("full_count", 32'(pending_count), 32'd31);
    reset = 1; wb_en = 1; wb_row = 5;
    tick(0);
    clear_strobes();
    check_all_zero("midreset");

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      reset     = ($urandom_range(0, 99) == 0);
      flush     = ($urandom_range(0, 11) == 0);
      alloc_en  = ($urandom_range(0, 2) != 0);
      alloc_reg = 5'($urandom_range(0, 31));
      alloc_row = 5'($urandom_range(0, 7));
      wb_en     = ($urandom_range(0, 1) != 0);
      wb_row    = 5'($urandom_range(0, 7));
      iss_rs_a  = 5'($urandom_range(0, 31));
      iss_rs_b  = 5'($urandom_range(0, 31));
      id_rs_a   = ($urandom_range(0, 3) == 0) ? alloc_reg : 5'($urandom_range(0, 31));
      id_rs_b   = 5'($urandom_range(0, 31));
      tick(1);
    end
    clear_strobes();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
